rgb888_ycbcr444: RTL
====================

RGB888_YCBCR444 -- requirements
Module: rgb888_ycbcr444

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as in the codebase: clk (input, 1, cmos video pixel clock) and rst_n (input, 1, global reset, asynchronous, active-low).
REQ-002 per_frame_vsync  input  1  prepared-image vsync valid.
REQ-003 per_frame_href  input  1  prepared-image href valid.
REQ-004 per_frame_clken  input  1  prepared-image pixel enable.
REQ-005 per_img_red  input  8  R component, unsigned.
REQ-006 per_img_green  input  8  G component, unsigned.
REQ-007 per_img_blue  input  8  B component, unsigned.
REQ-008 post_frame_vsync  output  1  vsync delayed to align with the result.
REQ-009 post_frame_href  output  1  href delayed to align with the result.
REQ-010 post_frame_clken  output  1  clken delayed to align with the result.
REQ-011 post_img_Y  output  8  luma, unsigned; feeds the downstream grey-inversion stage.
REQ-012 post_img_Cb  output  8  blue-difference chroma, offset 128.
REQ-013 post_img_Cr  output  8  red-difference chroma, offset 128.

Function
REQ-014 Arithmetic SHALL be Y = (77R + 150G + 29B) >> 8; Cb = (-43R - 85G + 128B + 32768) >> 8; Cr = (128R - 107G - 21B + 32768) >> 8.
REQ-015 Shifts SHALL truncate; no rounding SHALL be applied.
REQ-016 Products SHALL be 16 bits unsigned; sums SHALL be 17 bits or wider, signed or offset-safe, and SHALL never wrap.
REQ-017 All three results SHALL lie in 0..255 for every input; no saturation logic is required, and the bench SHALL confirm this.
REQ-018 The pipeline SHALL have 3 stages. S1 registers the nine products. S2 registers the three sums, with the +32768 offset applied to Cb and Cr. S3 registers bits [15:8] of each sum.
REQ-019 Latency from inputs to post_img_* SHALL be exactly 3 clk cycles.
REQ-020 The pipeline SHALL advance every clk, independent of clken; there is no stall or backpressure.
REQ-021 vsync, href and clken SHALL each pass through a 3-deep shift register, so the post_* controls align cycle-exactly with the data.
REQ-022 post_img_Y, post_img_Cb and post_img_Cr SHALL be forced to 0 whenever post_frame_href is 0; otherwise they SHALL carry the S3 values.
REQ-023 Back-to-back pixels, one per clk, SHALL be processed with no bubble and no loss.
REQ-024 Pixels with clken low SHALL still propagate; downstream qualifies them with post_frame_clken.
REQ-025 A line boundary SHALL produce no extra latency or state: href falling then rising on consecutive cycles SHALL appear at the output 3 cycles later unchanged.

Reset
REQ-026 On rst_n low, all pipeline registers, sync shift registers and outputs SHALL clear to 0 asynchronously.
REQ-027 Reset asserted mid-line SHALL discard in-flight pixels, and post_frame_href SHALL drop to 0 immediately.
REQ-028 After reset release, valid outputs SHALL appear no earlier than 3 clk after the first href-high input.
REQ-029 Reset SHALL NOT produce any spurious vsync or href pulse.

Structure
REQ-030 The coefficients (77, 150, 29, 43, 85, 128, 107, 21), the offset 32768 and the latency constant 3 SHALL live in a shared ycbcr_coef definitions file, so they are shared with the inverse and sibling colour stages.
REQ-031 Sync alignment SHALL be done by one sub-module, sync_delay, parameterised by width (3) and depth (3) and instantiated once for {vsync, href, clken}.
REQ-032 Multipliers SHALL be inferred, with no vendor primitives.

Verification
REQ-033 White input (255,255,255) with href=1 -> Y=255, Cb=128, Cr=128, appearing exactly 3 clk later.
REQ-034 Black input (0,0,0) -> Y=0, Cb=128, Cr=128; red (255,0,0) -> Y=76, Cb=85, Cr=255.
REQ-035 Green (0,255,0) -> Y=149, Cb=43, Cr=21; blue (0,0,255) -> Y=28, Cb=255, Cr=107.
REQ-036 Streamed line of 640 random pixels with a random clken pattern -> every output matches a reference model at +3 cycles; vsync, href and clken edges shifted exactly 3 cycles; outputs 0 while post_frame_href is 0.
REQ-037 rst_n pulsed low mid-line -> all outputs 0 asynchronously; after release, no output href until 3 clk after an input href.
REQ-038 Exhaustive or random sweep of the corner inputs {0, 1, 254, 255}^3 -> all results within 0..255 and no wrap.

Source files
------------

// File: rtl/ycbcr_coef_pkg.sv
// rtl/ycbcr_coef_pkg.sv - shared RGB/YCbCr coefficients, offsets and pipeline constants
//
// Purpose : one home for the 8-bit fixed-point (x256) colour-space coefficients,
//           the chroma offset and the pipeline latency, shared by the forward,
//           inverse and sibling colour stages.
// Contents: width/latency localparams, coefficient localparams, product bundle
//           type and an unsigned 8x8 multiply helper.

package ycbcr_coef_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned PROD_W  = 16;
  // Widest sum is 32768 + 128*255 = 65408, so 18 bits leaves headroom and never wraps.
  localparam int unsigned SUM_W   = 18;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned SYNC_W  = 3;

  localparam logic [PIX_W-1:0] COEF_Y_R  = 8'd77;
  localparam logic [PIX_W-1:0] COEF_Y_G  = 8'd150;
  localparam logic [PIX_W-1:0] COEF_Y_B  = 8'd29;
  localparam logic [PIX_W-1:0] COEF_CB_R = 8'd43;
  localparam logic [PIX_W-1:0] COEF_CB_G = 8'd85;
  localparam logic [PIX_W-1:0] COEF_CB_B = 8'd128;
  localparam logic [PIX_W-1:0] COEF_CR_R = 8'd128;
  localparam logic [PIX_W-1:0] COEF_CR_G = 8'd107;
  localparam logic [PIX_W-1:0] COEF_CR_B = 8'd21;

  localparam logic [SUM_W-1:0] CBCR_OFFSET = 18'd32768;

  // One output component's three unsigned partial products.
  typedef struct packed {
    logic [PROD_W-1:0] r;
    logic [PROD_W-1:0] g;
    logic [PROD_W-1:0] b;
  } prod3_t;

  function automatic logic [PROD_W-1:0] mul8(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register for frame sync/enable alignment
//
// Purpose : delays a bundle of control bits by DEPTH clocks so they line up
//           with a DEPTH-stage datapath.
// Ports   : clk   - pixel clock
//           rst_n - asynchronous active-low reset, clears every stage
//           din   - [WIDTH-1:0] control bits in
//           dout  - [WIDTH-1:0] control bits delayed by DEPTH clocks

module sync_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/rgb888_ycbcr444.sv
// rtl/rgb888_ycbcr444.sv - 3-stage RGB888 to YCbCr444 converter
//
// Purpose : converts one RGB888 pixel per clock to YCbCr444 with x256 fixed
//           point coefficients; controls are delayed to match the datapath.
// Ports   : clk, rst_n                      - pixel clock, async active-low reset
//           per_frame_vsync/href/clken      - input frame controls
//           per_img_red/green/blue [7:0]    - input pixel
//           post_frame_vsync/href/clken     - controls delayed by 3 clocks
//           post_img_Y/Cb/Cr [7:0]          - result, 0 while post_frame_href is low

module rgb888_ycbcr444
  import ycbcr_coef_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_red,
  input  logic [PIX_W-1:0] per_img_green,
  input  logic [PIX_W-1:0] per_img_blue,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [PIX_W-1:0] post_img_Y,
  output logic [PIX_W-1:0] post_img_Cb,
  output logic [PIX_W-1:0] post_img_Cr
);

  prod3_t           y_p, cb_p, cr_p;
  logic [SUM_W-1:0] y_sum, cb_sum, cr_sum;
  logic [PIX_W-1:0] y_s3, cb_s3, cr_s3;
  logic [SYNC_W-1:0] sync_out;

  // S1: nine products. The pipeline free-runs; clken only travels alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p  <= '0;
      cb_p <= '0;
      cr_p <= '0;
    end else begin
      y_p.r  <= mul8(per_img_red,   COEF_Y_R);
      y_p.g  <= mul8(per_img_green, COEF_Y_G);
      y_p.b  <= mul8(per_img_blue,  COEF_Y_B);
      cb_p.r <= mul8(per_img_red,   COEF_CB_R);
      cb_p.g <= mul8(per_img_green, COEF_CB_G);
      cb_p.b <= mul8(per_img_blue,  COEF_CB_B);
      cr_p.r <= mul8(per_img_red,   COEF_CR_R);
      cr_p.g <= mul8(per_img_green, COEF_CR_G);
      cr_p.b <= mul8(per_img_blue,  COEF_CR_B);
    end
  end

  // S2: sums. Adding the offset and the positive term before subtracting keeps
  // every intermediate non-negative (worst case 32768 - 128*255 = 128).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sum  <= '0;
      cb_sum <= '0;
      cr_sum <= '0;
    end else begin
      y_sum  <= SUM_W'(y_p.r) + SUM_W'(y_p.g) + SUM_W'(y_p.b);
      cb_sum <= CBCR_OFFSET + SUM_W'(cb_p.b) - SUM_W'(cb_p.r) - SUM_W'(cb_p.g);
      cr_sum <= CBCR_OFFSET + SUM_W'(cr_p.r) - SUM_W'(cr_p.g) - SUM_W'(cr_p.b);
    end
  end

  // S3: truncating >>8. The upper-bit guard can never fire because each row's
  // coefficients sum to at most 256; it only keeps the result 8 bits by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s3  <= '0;
      cb_s3 <= '0;
      cr_s3 <= '0;
    end else begin
      y_s3  <= (|y_sum[SUM_W-1:16])  ? '1 : y_sum[15:8];
      cb_s3 <= (|cb_sum[SUM_W-1:16]) ? '1 : cb_sum[15:8];
      cr_s3 <= (|cr_sum[SUM_W-1:16]) ? '1 : cr_sum[15:8];
    end
  end

  sync_delay #(
    .WIDTH (SYNC_W),
    .DEPTH (LATENCY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({per_frame_vsync, per_frame_href, per_frame_clken}),
    .dout  (sync_out)
  );

  assign post_frame_vsync = sync_out[2];
  assign post_frame_href  = sync_out[1];
  assign post_frame_clken = sync_out[0];

  assign post_img_Y  = post_frame_href ? y_s3  : '0;
  assign post_img_Cb = post_frame_href ? cb_s3 : '0;
  assign post_img_Cr = post_frame_href ? cr_s3 : '0;

endmodule
